// File: rtl/booth_pkg.sv
// Shared constants, digit type and iteration-count helper for the sequential Booth multiplier.
// Radix selection follows the BOOTH_RADIX4_EN macro (defined: radix-4, undefined: radix-2).
package booth_pkg;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

`ifdef BOOTH_RADIX4_EN
    localparam bit Radix4 = 1'b1;
`else
    localparam bit Radix4 = 1'b0;
`endif

    localparam int unsigned MinWidth = 2;
    localparam int unsigned MaxWidth = 32;

    // Recoded Booth digit: zero wins over the other flags; two selects 2*M.
    typedef struct packed {
        logic neg;
        logic zero;
        logic two;
    } booth_digit_t;

    function automatic int unsigned booth_iter(input int unsigned width, input bit radix4);
        return radix4 ? (width + 2) / 2 : width + 1;
    endfunction

    localparam int unsigned CntW = $clog2(booth_iter(MaxWidth, Radix4) + 1);

endpackage

// File: rtl/booth_mult_seq_if.sv
// Start/busy/done handshake bundle between a requester and booth_mult_seq.
interface booth_mult_seq_if #(
    parameter int unsigned WIDTH = 8
);

    logic               start;
    logic               tc;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [2*WIDTH-1:0] ab;
    logic               busy;
    logic               done;

    modport master (
        output start,
        output tc,
        output a,
        output b,
        input  ab,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  tc,
        input  a,
        input  b,
        output ab,
        output busy,
        output done
    );

endinterface

// File: rtl/booth_recode.sv
// Combinational Booth digit recoder: {q1, q0, q_-1} -> {neg, zero, two}.
// Radix-2 uses only {q0, q_-1} and never asserts two.
module booth_recode
    import booth_pkg::*;
#(
    parameter bit Radix4En = 1'b0
) (
    input  logic [2:0]   bits_i,
    output booth_digit_t digit_o
);

    logic unused_msb;
    assign unused_msb = bits_i[2];

    always_comb begin
        digit_o.neg  = 1'b0;
        digit_o.zero = 1'b1;
        digit_o.two  = 1'b0;
        if (Radix4En) begin
            unique case (bits_i)
                3'b001, 3'b010: begin
                    digit_o.zero = 1'b0;
                end
                3'b011: begin
                    digit_o.zero = 1'b0;
                    digit_o.two  = 1'b1;
                end
                3'b100: begin
                    digit_o.neg  = 1'b1;
                    digit_o.zero = 1'b0;
                    digit_o.two  = 1'b1;
                end
                3'b101, 3'b110: begin
                    digit_o.neg  = 1'b1;
                    digit_o.zero = 1'b0;
                end
                default: ;
            endcase
        end else begin
            unique case (bits_i[1:0])
                2'b01: begin
                    digit_o.zero = 1'b0;
                end
                2'b10: begin
                    digit_o.neg  = 1'b1;
                    digit_o.zero = 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential signed/unsigned Booth multiplier with start/busy/done handshake.
// BOOTH_RADIX4_EN selects radix-4 recoding (two multiplier bits per cycle); default is radix-2.
module booth_mult_seq #(
    parameter int unsigned WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    booth_mult_seq_if.slave bus
);
    import booth_pkg::*;

    localparam int unsigned Iter  = booth_iter(WIDTH, Radix4);
    localparam int unsigned AccW  = Radix4 ? WIDTH + 2 : WIDTH + 1;
    localparam int unsigned MulW  = Radix4 ? 2 * Iter : WIDTH + 1;
    localparam int unsigned Shift = Radix4 ? 2 : 1;
    // Two guard bits keep A +/- 2M exact before the shift discards them.
    localparam int unsigned SumW  = AccW + 2;

    if (WIDTH < MinWidth || WIDTH > MaxWidth) begin : g_width_check
        $error("booth_mult_seq: WIDTH must be within 2..32");
    end

    logic [0:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [AccW-1:0]    acc_q, acc_d;
    logic [AccW-1:0]    m_q, m_d;
    logic [MulW-1:0]    mq_q, mq_d;
    logic               qm1_q, qm1_d;
    logic [2*WIDTH-1:0] ab_q, ab_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               sign_a, sign_b;
    logic [AccW-1:0]    m_load;
    logic [MulW-1:0]    mq_load;

    booth_digit_t       digit;
    logic [SumW-1:0]    acc_sx, m_sx, pp, pp_sel, sum;
    logic [AccW-1:0]    step_acc;
    logic [MulW-1:0]    step_mq;
    logic               step_qm1;
    logic [AccW+MulW-1:0] prod_full;
    logic               unused_bits;

    assign sign_a  = bus.tc & bus.a[WIDTH-1];
    assign sign_b  = bus.tc & bus.b[WIDTH-1];
    assign m_load  = {{(AccW - WIDTH){sign_a}}, bus.a};
    assign mq_load = {{(MulW - WIDTH){sign_b}}, bus.b};

    booth_recode #(
        .Radix4En (Radix4)
    ) u_recode (
        .bits_i  ({mq_q[1], mq_q[0], qm1_q}),
        .digit_o (digit)
    );

    always_comb begin
        acc_sx = {{2{acc_q[AccW-1]}}, acc_q};
        m_sx   = {{2{m_q[AccW-1]}}, m_q};
        pp     = digit.two ? {m_sx[SumW-2:0], 1'b0} : m_sx;
        pp_sel = digit.zero ? '0 : (digit.neg ? -pp : pp);
        sum    = acc_sx + pp_sel;
    end

    // Arithmetic right shift of {A, Q, q_-1}; the sum's guard bits supply the true sign.
    assign step_acc  = sum[Shift +: AccW];
    assign step_mq   = {sum[Shift-1:0], mq_q[MulW-1:Shift]};
    assign step_qm1  = mq_q[Shift-1];
    assign prod_full = {step_acc, step_mq};

    assign unused_bits = ^{prod_full, sum};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        m_d     = m_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        ab_d    = ab_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    acc_d   = '0;
                    m_d     = m_load;
                    mq_d    = mq_load;
                    qm1_d   = 1'b0;
                    cnt_d   = CntW'(Iter);
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = step_acc;
                mq_d  = step_mq;
                qm1_d = step_qm1;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    ab_d    = prod_full[2*WIDTH-1:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            m_q     <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            ab_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            m_q     <= m_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.ab   = ab_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: vector table, scoreboard queue, corner sequences.
module tb_booth_mult_seq;

    localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
    localparam int Iter = (W + 2) / 2;
`else
    localparam int Iter = W + 1;
`endif

    logic clk;
    logic rst;

    booth_mult_seq_if #(.WIDTH(W)) bus ();

    booth_mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         tc;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] ab;
    } vec_t;

    vec_t vecs[12];
    logic [2*W-1:0] sb_q[$];
    logic [2*W-1:0] last_exp;
    int checks   = 0;
    int failures = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic t, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        longint sx, sy;
        logic [63:0] p;
        sx = t ? longint'($signed(x)) : longint'(x);
        sy = t ? longint'($signed(y)) : longint'(y);
        p  = 64'(sx * sy);
        return p[2*W-1:0];
    endfunction

    task automatic issue(input logic t, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        bus.start = 1'b1;
        bus.tc    = t;
        bus.a     = x;
        bus.b     = y;
        last_exp  = model(t, x, y);
        sb_q.push_back(last_exp);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int k = 0; k < Iter + 4 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 64'(seen), 64'd1);
    endtask

    // Scoreboard: every done pulse pops one expected product and checks latency.
    always @(negedge clk) begin
        logic [2*W-1:0] exp_ab;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'(bus.ab), 64'hDEAD_BEEF);
                end else begin
                    exp_ab = sb_q.pop_front();
                    check("ab", 64'(bus.ab), 64'(exp_ab));
                end
                check("latency", 64'(busy_cnt), 64'(Iter));
                busy_cnt = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 8'd3,   8'd17,  16'd51};
        vecs[1]  = '{1'b0, 8'd7,   8'd7,   16'd49};
        vecs[2]  = '{1'b0, 8'd255, 8'd255, 16'hFE01};
        vecs[3]  = '{1'b1, 8'hFD,  8'd17,  16'hFFCD};
        vecs[4]  = '{1'b1, 8'h80,  8'h80,  16'h4000};
        vecs[5]  = '{1'b1, 8'hFF,  8'hFF,  16'h0001};
        vecs[6]  = '{1'b1, 8'h80,  8'h7F,  16'hC080};
        vecs[7]  = '{1'b0, 8'd0,   8'd255, 16'h0000};
        vecs[8]  = '{1'b1, 8'h7F,  8'h7F,  16'h3F01};
        vecs[9]  = '{1'b0, 8'd128, 8'd2,   16'h0100};
        vecs[10] = '{1'b1, 8'hFF,  8'h01,  16'hFFFF};
        vecs[11] = '{1'b0, 8'hFF,  8'h80,  16'h7F80};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.tc    = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset_ab", 64'(bus.ab), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        rst = 1'b0;

        // Table: each op after the first starts in the previous op's done cycle.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].tc, vecs[i].a, vecs[i].b);
            check("table_model", 64'(last_exp), 64'(vecs[i].ab));
            check("table_busy", 64'(bus.busy), 64'd1);
            wait_done("table");
        end

        // start while busy must be ignored; ab holds the previous result.
        repeat (2) @(negedge clk);
        issue(1'b0, 8'd5, 8'd6);
        check("hold_ab_on_start", 64'(bus.ab), 64'(vecs[11].ab));
        bus.start = 1'b1;
        bus.a     = 8'd1;
        bus.b     = 8'd1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("ignore_start");
        check("ignore_start_ab", 64'(bus.ab), 64'd30);
        repeat (Iter + 3) @(negedge clk);
        check("ab_held_idle", 64'(bus.ab), 64'd30);

        // Asynchronous reset mid-operation discards the op.
        issue(1'b0, 8'd9, 8'd9);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_ab", 64'(bus.ab), 64'd0);
        check("rst_mid_done", 64'(bus.done), 64'd0);
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (Iter + 3) @(negedge clk);
        check("no_done_after_rst", 64'(sb_q.size()), 64'd0);
        issue(1'b0, 8'd2, 8'd3);
        wait_done("after_rst");
        check("after_rst_ab", 64'(bus.ab), 64'd6);

        // Random operations with random idle gaps.
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
            wait_done("random");
        end

        repeat (Iter + 3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
